// File: rtl/ternary_fabric_pkg.sv
// Shared definitions for the ternary fabric lane engines: trit encodings,
// geometry constants, sequencer state encoding and the trit product helper.
package ternary_fabric_pkg;

   localparam int LANES          = 15;
   localparam int TRITS_PER_WORD = 12;
   localparam int SRAM_AW        = 10;
   localparam int ACC_W          = 32;

   typedef enum logic [1:0] {
      TRIT_ZERO = 2'b00,
      TRIT_POS  = 2'b01,
      TRIT_INV  = 2'b10,
      TRIT_NEG  = 2'b11
   } trit_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE,
      ST_HOLD
   } seq_state_e;

   // Invalid codes behave as zero, so only POS/NEG pairs contribute.
   function automatic logic signed [4:0] trit_prod(input logic [1:0] a, input logic [1:0] b);
      logic a_nz;
      logic b_nz;
      a_nz = (a == TRIT_POS) || (a == TRIT_NEG);
      b_nz = (b == TRIT_POS) || (b == TRIT_NEG);
      if (!(a_nz && b_nz))
         return 5'sd0;
      return (a == b) ? 5'sd1 : -5'sd1;
   endfunction

endpackage

// File: rtl/ternary_lane_sequencer_if.sv
// Bundle between the AXI control/SRAM-load interconnect, the two SRAMs and
// the lane sequencer. The sequencer side uses the slave modport.
interface ternary_lane_sequencer_if #(
   parameter int LANES = ternary_fabric_pkg::LANES,
   parameter int AW    = ternary_fabric_pkg::SRAM_AW,
   parameter int ACC_W = ternary_fabric_pkg::ACC_W
);
   // Handshake: fabric_start is a level held until fabric_done (one-cycle
   // pulse) is seen; SRAM rdata is valid the cycle after its re strobe.
   logic                   fabric_start;
   logic [31:0]            fabric_base_addr;
   logic [15:0]            fabric_depth;
   logic [7:0]             fabric_stride;
   logic [31:0]            fabric_exec_hints;
   logic [15:0]            fabric_lane_count;
   logic                   fabric_done;
   logic                   busy;
   logic [LANES*ACC_W-1:0] vector_results;
   logic                   weight_re;
   logic [AW-1:0]          weight_raddr;
   logic [23:0]            weight_rdata;
   logic                   input_re;
   logic [AW-1:0]          input_raddr;
   logic [23:0]            input_rdata;

   modport slave (
      input  fabric_start, fabric_base_addr, fabric_depth, fabric_stride,
             fabric_exec_hints, fabric_lane_count, weight_rdata, input_rdata,
      output fabric_done, busy, vector_results, weight_re, weight_raddr,
             input_re, input_raddr
   );

   modport master (
      output fabric_start, fabric_base_addr, fabric_depth, fabric_stride,
             fabric_exec_hints, fabric_lane_count, weight_rdata, input_rdata,
      input  fabric_done, busy, vector_results, weight_re, weight_raddr,
             input_re, input_raddr
   );

endinterface

// File: rtl/ternary_dot12.sv
// Combinational signed dot product of two packed 12-trit words (-12..+12).
module ternary_dot12
   import ternary_fabric_pkg::*;
(
   input  logic [2*TRITS_PER_WORD-1:0] i_w,
   input  logic [2*TRITS_PER_WORD-1:0] i_x,
   output logic signed [4:0]           o_dot
);

   always_comb begin
      o_dot = '0;
      for (int t = 0; t < TRITS_PER_WORD; t++)
         o_dot = o_dot + trit_prod(i_w[2*t +: 2], i_x[2*t +: 2]);
   end

endmodule

// File: rtl/ternary_lane_sequencer.sv
// Lane-major ternary dot-product sequencer: streams weight/input word pairs
// from the SRAMs and accumulates one signed 32-bit result per lane.
module ternary_lane_sequencer
   import ternary_fabric_pkg::*;
(
   input  logic                     s_axi_aclk,
   input  logic                     s_axi_areset,
   ternary_lane_sequencer_if.slave  bus,
   output seq_state_e               o_state
);

   localparam int AW = SRAM_AW;

   seq_state_e          r_state;
   logic [AW-1:0]       r_row;
   logic [AW-1:0]       r_waddr;
   logic [AW-1:0]       r_iaddr;
   logic [15:0]         r_depth;
   logic [15:0]         r_k;
   logic [7:0]          r_stride;
   logic [3:0]          r_lanes;
   logic [3:0]          r_l;
   logic [3:0]          r_lane_d;
   logic                r_re;
   logic                r_vld;
   logic                r_done;
   logic [ACC_W-1:0]    r_acc [LANES];

   logic [3:0]          w_lanes;
   logic                w_empty;
   logic                w_last_k;
   logic                w_last;
   logic                w_clear;
   logic signed [4:0]   w_dot;
   logic                w_unused_cfg;

   assign w_lanes  = (bus.fabric_lane_count > 16'(LANES)) ? 4'(LANES) : bus.fabric_lane_count[3:0];
   assign w_empty  = (w_lanes == 4'd0) || (bus.fabric_depth == 16'd0);
   assign w_last_k = (r_k == r_depth - 16'd1);
   assign w_last   = w_last_k && (r_l == r_lanes - 4'd1);
   assign w_clear  = (r_state == ST_IDLE) && bus.fabric_start && !bus.fabric_exec_hints[0];
   assign w_unused_cfg = ^{bus.fabric_base_addr[31:AW], bus.fabric_exec_hints[31:1]};

   ternary_dot12 u_dot12 (
      .i_w   (bus.weight_rdata),
      .i_x   (bus.input_rdata),
      .o_dot (w_dot)
   );

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         r_state  <= ST_IDLE;
         r_row    <= '0;
         r_waddr  <= '0;
         r_iaddr  <= '0;
         r_depth  <= '0;
         r_k      <= '0;
         r_stride <= '0;
         r_lanes  <= '0;
         r_l      <= '0;
         r_lane_d <= '0;
         r_re     <= 1'b0;
         r_vld    <= 1'b0;
         r_done   <= 1'b0;
         for (int i = 0; i < LANES; i++)
            r_acc[i] <= '0;
      end else begin
         // Lane index travels one cycle behind the read it belongs to.
         r_vld    <= r_re;
         r_lane_d <= r_l;
         r_done   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.fabric_start) begin
                  r_depth  <= bus.fabric_depth;
                  r_stride <= bus.fabric_stride;
                  r_lanes  <= w_lanes;
                  r_row    <= bus.fabric_base_addr[AW-1:0];
                  r_waddr  <= bus.fabric_base_addr[AW-1:0];
                  r_iaddr  <= '0;
                  r_k      <= '0;
                  r_l      <= '0;
                  r_re     <= !w_empty;
                  r_state  <= w_empty ? ST_DRAIN : ST_RUN;
               end
            end
            ST_RUN: begin
               if (w_last) begin
                  r_re    <= 1'b0;
                  r_state <= ST_DRAIN;
               end else if (w_last_k) begin
                  r_k     <= '0;
                  r_l     <= r_l + 4'd1;
                  r_row   <= r_row + AW'(r_stride);
                  r_waddr <= r_row + AW'(r_stride);
                  r_iaddr <= '0;
               end else begin
                  r_k     <= r_k + 16'd1;
                  r_waddr <= r_waddr + AW'(1);
                  r_iaddr <= r_iaddr + AW'(1);
               end
            end
            ST_DRAIN: begin
               r_done  <= 1'b1;
               r_state <= ST_DONE;
            end
            ST_DONE: r_state <= ST_HOLD;
            ST_HOLD: if (!bus.fabric_start) r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
         for (int i = 0; i < LANES; i++) begin
            if (w_clear)
               r_acc[i] <= '0;
            else if (r_vld && (r_lane_d == 4'(i)))
               r_acc[i] <= r_acc[i] + {{(ACC_W-5){w_dot[4]}}, w_dot};
         end
      end
   end

   assign bus.fabric_done  = r_done;
   assign bus.busy         = (r_state == ST_RUN) || (r_state == ST_DRAIN) || (r_state == ST_DONE) ||
                             ((r_state == ST_IDLE) && bus.fabric_start);
   assign bus.weight_re    = r_re;
   assign bus.weight_raddr = r_waddr;
   assign bus.input_re     = r_re;
   assign bus.input_raddr  = r_iaddr;
   assign o_state          = r_state;

   always_comb begin
      bus.vector_results = '0;
      for (int i = 0; i < LANES; i++)
         bus.vector_results[i*ACC_W +: ACC_W] = r_acc[i];
   end

endmodule

// File: tb/tb_ternary_lane_sequencer.sv
// Directed bench for ternary_lane_sequencer with SRAM models, a reference
// dot-product model and expected-value queues for results and read addresses.
module tb_ternary_lane_sequencer;
   import ternary_fabric_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ternary_lane_sequencer_if bus ();
   seq_state_e dut_state;

   ternary_lane_sequencer dut (
      .s_axi_aclk   (clk),
      .s_axi_areset (rst),
      .bus          (bus),
      .o_state      (dut_state)
   );

   logic [23:0] wmem [1024];
   logic [23:0] xmem [1024];

   always @(posedge clk) begin
      if (bus.weight_re) bus.weight_rdata <= wmem[bus.weight_raddr];
      if (bus.input_re)  bus.input_rdata  <= xmem[bus.input_raddr];
   end

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_q [$];
   logic [9:0]  exp_wa_q [$];
   logic [9:0]  exp_ia_q [$];
   logic [31:0] m_acc [15];

   function automatic int tval(input logic [1:0] t);
      case (t)
         2'b01:   return 1;
         2'b11:   return -1;
         default: return 0;
      endcase
   endfunction

   function automatic int dot_ref(input logic [23:0] w, input logic [23:0] x);
      int s;
      s = 0;
      for (int t = 0; t < 12; t++)
         s += tval(w[2*t +: 2]) * tval(x[2*t +: 2]);
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_done"}, bus.fabric_done, 0);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_wre"}, bus.weight_re, 0);
      chk({tag, "_xre"}, bus.input_re, 0);
      chk({tag, "_waddr"}, bus.weight_raddr, 0);
      chk({tag, "_xaddr"}, bus.input_raddr, 0);
      chk({tag, "_state"}, dut_state, ST_IDLE);
      for (int i = 0; i < 15; i++)
         chk($sformatf("%s_lane%0d", tag, i), bus.vector_results[i*32 +: 32], 0);
   endtask

   task automatic run(input logic [31:0] base, input logic [15:0] depth, input logic [7:0] stride,
                      input logic hint, input logic [15:0] count);
      int l_n, span, done_at, done_cnt, a;
      l_n  = (count > 16'd15) ? 15 : int'(count);
      span = l_n * int'(depth);
      if (!hint)
         for (int i = 0; i < 15; i++) m_acc[i] = '0;
      for (int l = 0; l < l_n; l++)
         for (int k = 0; k < int'(depth); k++) begin
            a = (int'(base[9:0]) + l * int'(stride) + k) % 1024;
            exp_wa_q.push_back(a[9:0]);
            exp_ia_q.push_back(k[9:0]);
            m_acc[l] = m_acc[l] + 32'(dot_ref(wmem[a], xmem[k % 1024]));
         end
      for (int i = 0; i < 15; i++) exp_q.push_back(m_acc[i]);

      @(negedge clk);
      bus.fabric_base_addr  = base;
      bus.fabric_depth      = depth;
      bus.fabric_stride     = stride;
      bus.fabric_exec_hints = {31'($urandom), hint};
      bus.fabric_lane_count = count;
      bus.fabric_start      = 1'b1;
      #1;
      chk("busy_launch", bus.busy, 1);

      done_at  = -1;
      done_cnt = 0;
      for (int n = 1; n <= span + 7; n++) begin
         @(negedge clk);
         if (n == 1) begin
            bus.fabric_base_addr  = $urandom;
            bus.fabric_depth      = 16'($urandom);
            bus.fabric_stride     = 8'($urandom);
            bus.fabric_exec_hints = $urandom;
            bus.fabric_lane_count = 16'($urandom);
         end
         chk("w_re", bus.weight_re, 32'(n <= span));
         chk("x_re", bus.input_re, 32'(n <= span));
         if (bus.weight_re) begin
            chk("rd_expected", 32'(exp_wa_q.size() != 0), 1);
            if (exp_wa_q.size() != 0) begin
               chk("w_addr", bus.weight_raddr, exp_wa_q.pop_front());
               chk("x_addr", bus.input_raddr, exp_ia_q.pop_front());
            end
         end
         chk("busy", bus.busy, 32'(n <= span + 2));
         if (bus.fabric_done) begin
            done_cnt++;
            if (done_at < 0) done_at = n;
         end
      end
      chk("done_cycle", done_at, span + 2);
      chk("done_count", done_cnt, 1);
      chk("state_hold", dut_state, ST_HOLD);
      chk("rd_left", exp_wa_q.size(), 0);
      for (int i = 0; i < 15; i++)
         chk($sformatf("lane%0d", i), bus.vector_results[i*32 +: 32], exp_q.pop_front());
      bus.fabric_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("state_idle", dut_state, ST_IDLE);
   endtask

   initial begin
      rst = 1'b1;
      bus.fabric_start      = 1'b0;
      bus.fabric_base_addr  = '0;
      bus.fabric_depth      = '0;
      bus.fabric_stride     = '0;
      bus.fabric_exec_hints = '0;
      bus.fabric_lane_count = '0;
      for (int i = 0; i < 1024; i++) begin
         wmem[i] = 24'($urandom);
         xmem[i] = 24'($urandom);
      end
      for (int i = 0; i < 15; i++) m_acc[i] = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst = 1'b0;

      // Basic single-word run, then the same run accumulating on top.
      wmem[0] = 24'h000001;
      xmem[0] = 24'h000003;
      run(32'h0, 16'd1, 8'd0, 1'b0, 16'd1);
      chk("basic_lane0", bus.vector_results[31:0], 32'hFFFFFFFF);
      run(32'h0, 16'd1, 8'd0, 1'b1, 16'd1);
      chk("accum_lane0", bus.vector_results[31:0], 32'hFFFFFFFE);

      // Three lanes, depth two, stride four, all +1 words.
      for (int l = 0; l < 3; l++)
         for (int k = 0; k < 2; k++) wmem[16 + 4*l + k] = 24'h555555;
      xmem[0] = 24'h555555;
      xmem[1] = 24'h555555;
      run(32'h10, 16'd2, 8'd4, 1'b0, 16'd3);
      for (int i = 0; i < 3; i++)
         chk($sformatf("multi_lane%0d", i), bus.vector_results[i*32 +: 32], 32'd24);

      // All-invalid weight word contributes nothing.
      wmem[0] = 24'hAAAAAA;
      run(32'h0, 16'd1, 8'd0, 1'b0, 16'd1);
      chk("invalid_lane0", bus.vector_results[31:0], 32'd0);

      // Weight address wraps from 0x3FF to 0x000.
      run(32'h3FF, 16'd2, 8'd0, 1'b0, 16'd1);

      // Empty configurations.
      run(32'h5, 16'd5, 8'd3, 1'b0, 16'd0);
      run(32'h5, 16'd0, 8'd3, 1'b0, 16'd3);

      // Random contents: over-range lane count, then a generic run.
      run($urandom, 16'd3, 8'($urandom_range(0, 255)), 1'b0, 16'd40);
      run($urandom, 16'd7, 8'($urandom_range(0, 255)), 1'b1, 16'd5);

      // Reset in the middle of a run, then accumulate onto the cleared bank.
      @(negedge clk);
      bus.fabric_base_addr  = 32'h40;
      bus.fabric_depth      = 16'd4;
      bus.fabric_stride     = 8'd8;
      bus.fabric_exec_hints = '0;
      bus.fabric_lane_count = 16'd2;
      bus.fabric_start      = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      bus.fabric_start = 1'b0;
      @(negedge clk);
      check_reset_outputs("midrst");
      rst = 1'b0;
      for (int i = 0; i < 15; i++) m_acc[i] = '0;
      run(32'h40, 16'd4, 8'd8, 1'b1, 16'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
